// File: rtl/game_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Package     : game_pkg
// Description : Shared types and helpers for the snake game-flow controller.
//               state_t is the encoding driven on game_sequencer.state.
//               tick_period() computes the score-dependent move-tick period.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int SCORE_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  // period = max(tick_div - score*step, min_div), evaluated in 32 bits.
  // The difference is treated as signed so an over-large speed-up (negative
  // result) saturates to min_div instead of wrapping to a huge period.
  function automatic logic [31:0] tick_period(
    input logic [SCORE_W-1:0] score,
    input logic [31:0]        tick_div,
    input logic [31:0]        min_div,
    input logic [31:0]        step
  );
    logic [31:0]        dec;
    logic signed [31:0] diff;
    dec  = {{(32-SCORE_W){1'b0}}, score} * step;
    diff = $signed(tick_div - dec);
    if (diff < $signed(min_div)) begin
      return min_div;
    end
    return $unsigned(diff);
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_sequencer_move_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : move_tick_gen
// Description : Programmable divider producing the snake move tick.
//               Counts 0..period-1 while en is high; tick pulses for one
//               cycle after the terminal count and the counter restarts.
//               The period is captured on load and re-captured at every
//               wrap, so a new speed takes effect on the next full period.
//               With en low the count is frozen (used for pause).
// Ports       : clk, nRst (async, active-low)
//               en     - count enable
//               load   - restart count at 0 and capture period
//               period - cycles per tick (32 bit)
//               tick   - registered 1-cycle pulse
// Revision    : 1.0 - initial release
// ============================================================================
module move_tick_gen (
  input  logic        clk,
  input  logic        nRst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] r_count;
  logic [31:0] r_period;
  logic        w_last;

  // >= rather than == so a count can never run past the terminal value
  assign w_last = (r_count >= (r_period - 32'd1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_count  <= '0;
      r_period <= '0;
      tick     <= 1'b0;
    end else if (load) begin
      r_count  <= '0;
      r_period <= period;
      tick     <= 1'b0;
    end else if (en) begin
      if (w_last) begin
        r_count  <= '0;
        r_period <= period;
        tick     <= 1'b1;
      end else begin
        r_count  <= r_count + 32'd1;
        tick     <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : game_sequencer
// Description : Game-flow controller. Converts start/collision levels into
//               1-cycle score_inc/score_clr commands, generates the
//               score-dependent move tick and selects current/high score
//               for the display.
// Ports       : clk, nRst (async, active-low)
//               start_btn, good_coll, bad_coll - input levels
//               cur_score [SCORE_W]           - score tracker feedback
//               score_inc, score_clr, move_tick - 1-cycle pulses
//               show_high (1 = high score), game_over, state (state_t)
// Config      : GAME_PAUSE_EN - start rise toggles RUN <-> PAUSED
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1_500_000,
  parameter int unsigned MIN_DIV      = 500_000,
  parameter int unsigned SPEEDUP_STEP = 100_000,
  parameter int unsigned MAX_SCORE    = 50,
  parameter int unsigned OVER_HOLD    = 50_000_000
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start_btn,
  input  logic               good_coll,
  input  logic               bad_coll,
  input  logic [SCORE_W-1:0] cur_score,
  output logic               score_inc,
  output logic               score_clr,
  output logic               move_tick,
  output logic               show_high,
  output logic               game_over,
  output logic [1:0]         state
);

  localparam logic [1:0] c_st_idle   = IDLE;
  localparam logic [1:0] c_st_run    = RUN;
  localparam logic [1:0] c_st_paused = PAUSED;
  localparam logic [1:0] c_st_over   = OVER;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        r_start_q;
  logic        r_good_q;
  logic [31:0] r_hold_cnt;
  logic        w_start_rise;
  logic        w_good_rise;
  logic        w_stay_run;
  logic        w_enter_run;
  logic [31:0] w_period;

  assign w_start_rise = start_btn & ~r_start_q;
  assign w_good_rise  = good_coll & ~r_good_q;
  assign w_period     = tick_period(cur_score, TICK_DIV, MIN_DIV, SPEEDUP_STEP);

  // Only a fresh game (from IDLE) restarts the divider; resuming from pause
  // keeps the frozen count.
  assign w_enter_run  = (r_state == c_st_idle) && (w_next == c_st_run);
  // Tick and score pulses are only produced when the next cycle is still
  // RUN, so neither can leak into OVER or PAUSED.
  assign w_stay_run   = (r_state == c_st_run) && (w_next == c_st_run);

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_start_rise) w_next = c_st_run;
      end
      c_st_run: begin
        // bad_coll wins over everything else in the same cycle
        if (bad_coll || ({{(32-SCORE_W){1'b0}}, cur_score} >= MAX_SCORE)) begin
          w_next = c_st_over;
        end
`ifdef GAME_PAUSE_EN
        else if (w_start_rise) begin
          w_next = c_st_paused;
        end
`endif
      end
      c_st_paused: begin
`ifdef GAME_PAUSE_EN
        if (w_start_rise) w_next = c_st_run;
`else
        w_next = c_st_idle;
`endif
      end
      c_st_over: begin
        if (r_hold_cnt >= (OVER_HOLD - 32'd1)) w_next = c_st_idle;
      end
      default: w_next = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= c_st_idle;
      r_start_q  <= 1'b0;
      r_good_q   <= 1'b0;
      r_hold_cnt <= '0;
      score_inc  <= 1'b0;
      score_clr  <= 1'b0;
      show_high  <= 1'b1;
      game_over  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_start_q  <= start_btn;
      r_good_q   <= good_coll;
      r_hold_cnt <= (r_state == c_st_over) ? (r_hold_cnt + 32'd1) : 32'd0;
      score_inc  <= w_stay_run && w_good_rise;
      score_clr  <= w_enter_run;
      show_high  <= (w_next == c_st_idle) || (w_next == c_st_over);
      game_over  <= (w_next == c_st_over);
    end
  end

  move_tick_gen u_move_tick_gen (
    .clk    (clk),
    .nRst   (nRst),
    .en     (w_stay_run),
    .load   (w_enter_run),
    .period (w_period),
    .tick   (move_tick)
  );

  assign state = r_state;

endmodule

`default_nettype wire
